// File: rtl/octree_cmd_sequencer_if.sv
// Command/response/CSR bundle between the host, the octree command sequencer
// and the octree engine. The sequencer takes the slave modport; the host and
// engine side take master.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised, its payload is held stable until that
// transfer. ready may be raised or lowered at any time, and valid never waits
// for ready. This applies to cmd_* (host -> sequencer) and rsp_* (sequencer
// -> host).
interface octree_cmd_sequencer_if #(
  parameter int ENCODE_ADDR_WIDTH = 18,
  parameter int DEPTH             = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [ENCODE_ADDR_WIDTH-1:0] cmd_pos_encode;
  logic [1:0]                   csr_ctrl;
  logic [ENCODE_ADDR_WIDTH-1:0] csr_pos_encode;
  logic [1:0]                   csr_op_done;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [1:0]                   rsp_op;
  logic [1:0]                   rsp_status;
  logic                         busy;
  logic [LW-1:0]                queue_level;
  logic [15:0]                  stat_ok_cnt;
  logic [15:0]                  stat_err_cnt;

  modport slave (
    input  cmd_valid, cmd_op, cmd_pos_encode, csr_op_done, rsp_ready,
    output cmd_ready, csr_ctrl, csr_pos_encode, rsp_valid, rsp_op, rsp_status,
           busy, queue_level, stat_ok_cnt, stat_err_cnt
  );

  modport master (
    output cmd_valid, cmd_op, cmd_pos_encode, csr_op_done, rsp_ready,
    input  cmd_ready, csr_ctrl, csr_pos_encode, rsp_valid, rsp_op, rsp_status,
           busy, queue_level, stat_ok_cnt, stat_err_cnt
  );
endinterface

// File: rtl/octree_cmd_sequencer.sv
// Octree command sequencer: queues host add/delete/search commands, issues
// them one at a time on the engine CSR lines, waits for the done code, and
// returns a status response (OK / timeout / mismatch / illegal op).
// Optional statistics counters are built when OCTREE_CMDQ_STATS_EN is defined.
module octree_cmd_sequencer #(
  parameter int ENCODE_ADDR_WIDTH = 18,
  parameter int DEPTH             = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  octree_cmd_sequencer_if.slave bus,
  output logic [1:0]            dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // Command FIFO storage and bookkeeping
  logic [1:0]                   op_mem  [DEPTH];
  logic [ENCODE_ADDR_WIDTH-1:0] pos_mem [DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [LW-1:0]                level;
  logic                         full, empty, push, pop;
  logic [1:0]                   cur_op;
  logic [ENCODE_ADDR_WIDTH-1:0] cur_pos;

  // Registered outputs and in-flight command context
  logic [1:0]                   ctrl_q, ctrl_d;
  logic [ENCODE_ADDR_WIDTH-1:0] pos_q, pos_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [1:0]                   rsp_op_q, rsp_op_d;
  logic [1:0]                   rsp_status_q, rsp_status_d;
  logic [1:0]                   act_op_q, act_op_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic                         taken_q, taken_d;
  logic                         drained_q, drained_d;

  // Decoded events used by both the next-state and output logic
  logic done_match, done_mism, timer_max, wait_exit;
  logic accept, drain_now, resp_exit;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push    = bus.cmd_valid && !full;
  assign pop     = (state == S_IDLE) && !empty;
  assign cur_op  = op_mem[rd_ptr];
  assign cur_pos = pos_mem[rd_ptr];

  assign done_match = (bus.csr_op_done == act_op_q);
  assign done_mism  = (bus.csr_op_done != 2'd0) && !done_match;
  assign timer_max  = (timer_q == TMAX);
  assign wait_exit  = done_match || done_mism || timer_max;
  assign accept     = rsp_valid_q && bus.rsp_ready;
  // A done line stuck nonzero for the full timeout counts as drained
  assign drain_now  = (bus.csr_op_done == 2'd0) || timer_max;
  assign resp_exit  = (taken_q || accept) && (drained_q || drain_now);

  // FIFO pointers and occupancy; full blocks pushes even when popping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= bus.cmd_op;
      pos_mem[wr_ptr] <= bus.cmd_pos_encode;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state: illegal ops skip WAIT and respond directly
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (pop) state_next = (cur_op != 2'd0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_exit) state_next = S_RESP;
      S_RESP: if (resp_exit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM output/datapath next values; everything holds unless updated here
  always_comb begin
    ctrl_d       = ctrl_q;
    pos_d        = pos_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_status_d = rsp_status_q;
    act_op_d     = act_op_q;
    timer_d      = timer_q;
    taken_d      = taken_q;
    drained_d    = drained_q;
    case (state)
      S_IDLE: begin
        if (pop) begin
          act_op_d = cur_op;
          timer_d  = '0;
          if (cur_op != 2'd0) begin
            ctrl_d = cur_op;
            pos_d  = cur_pos;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_op_d     = 2'd0;
            rsp_status_d = 2'd3;
            taken_d      = 1'b0;
            drained_d    = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (wait_exit) begin
          ctrl_d      = 2'd0;
          rsp_valid_d = 1'b1;
          rsp_op_d    = act_op_q;
          // A matching done code beats a coincident timeout
          if (done_match)     rsp_status_d = 2'd0;
          else if (done_mism) rsp_status_d = 2'd2;
          else                rsp_status_d = 2'd1;
          timer_d   = '0;
          taken_d   = 1'b0;
          drained_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (accept) begin
          rsp_valid_d = 1'b0;
          taken_d     = 1'b1;
        end
        if (drain_now)       drained_d = 1'b1;
        else if (!drained_q) timer_d   = timer_q + TW'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and command context
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q       <= 2'd0;
      pos_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 2'd0;
      rsp_status_q <= 2'd0;
      act_op_q     <= 2'd0;
      timer_q      <= '0;
      taken_q      <= 1'b0;
      drained_q    <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      pos_q        <= pos_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_status_q <= rsp_status_d;
      act_op_q     <= act_op_d;
      timer_q      <= timer_d;
      taken_q      <= taken_d;
      drained_q    <= drained_d;
    end
  end

  assign bus.cmd_ready      = !full;
  assign bus.csr_ctrl       = ctrl_q;
  assign bus.csr_pos_encode = pos_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_op         = rsp_op_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.busy           = (state != S_IDLE) || !empty;
  assign bus.queue_level    = level;
  assign dbg_state          = state;

`ifdef OCTREE_CMDQ_STATS_EN
  logic [15:0] ok_cnt, err_cnt;

  // Saturating response statistics, counted on response acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else if (accept) begin
      if (rsp_status_q == 2'd0) begin
        if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
      end else begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign bus.stat_ok_cnt  = ok_cnt;
  assign bus.stat_err_cnt = err_cnt;
`else
  assign bus.stat_ok_cnt  = 16'd0;
  assign bus.stat_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_octree_cmd_sequencer.sv
// Testbench for octree_cmd_sequencer: directed steps plus randomized commands,
// checked against a command-level reference model.
module tb_octree_cmd_sequencer;
  localparam int EW = 18;
  localparam int DP = 8;
  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  octree_cmd_sequencer_if #(.ENCODE_ADDR_WIDTH(EW), .DEPTH(DP)) bus ();

  octree_cmd_sequencer #(
    .ENCODE_ADDR_WIDTH(EW),
    .DEPTH(DP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int ok_n     = 0;
  int err_n    = 0;
  logic [EW+1:0] exp_q[$];   // queued commands {op, pos} in host order

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: one host push; the sequencer must be ready
  task automatic push(input logic [1:0] op, input logic [EW-1:0] pos);
    bus.cmd_valid      = 1'b1;
    bus.cmd_op         = op;
    bus.cmd_pos_encode = pos;
    check("push_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    exp_q.push_back({op, pos});
  endtask

  // Driver + model: called in the cycle the command was popped. The engine
  // answers 'code' 'delay' cycles after issue (never when code==0); the host
  // holds rsp_ready low for 'hold' cycles after the response appears.
  task automatic serve(input int delay, input logic [1:0] code, input int hold);
    logic [1:0]    op;
    logic [EW-1:0] pos;
    logic [1:0]    st;
    int            exit_k;
    {op, pos} = exp_q.pop_front();
    if (op == 2'd0) begin
      st = 2'd3; exit_k = 0;
    end else if (code != 2'd0 && delay <= TO) begin
      exit_k = delay; st = (code == op) ? 2'd0 : 2'd2;
    end else begin
      exit_k = TO; st = 2'd1;
    end
    if (op != 2'd0) begin
      check("issue_ctrl", 32'(bus.csr_ctrl), 32'(op));
      check("issue_pos", 32'(bus.csr_pos_encode), 32'(pos));
      for (int k = 1; k <= exit_k; k++) begin
        if (k == delay && code != 2'd0) bus.csr_op_done = code;
        tick();
        if (k < exit_k)
          check("wait_hold", 32'({bus.rsp_valid, bus.csr_ctrl}), 32'({1'b0, op}));
      end
      check("exit_pos", 32'(bus.csr_pos_encode), 32'(pos));
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_ctrl_off", 32'(bus.csr_ctrl), 32'd0);
    check("rsp_op", 32'(bus.rsp_op), 32'(op));
    check("rsp_status", 32'(bus.rsp_status), 32'(st));
    bus.csr_op_done = 2'd0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("rsp_stall", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_status, bus.csr_ctrl}),
            32'({1'b1, op, st, 2'd0}));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    if (st == 2'd0) ok_n++; else err_n++;
    check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'(bus.csr_ctrl), 32'd0);
    check({tag, "_pos"}, 32'(bus.csr_pos_encode), 32'd0);
    check({tag, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_status}), 32'd0);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_level"}, 32'(bus.queue_level), 32'd0);
    check({tag, "_stats"}, 32'({bus.stat_ok_cnt, bus.stat_err_cnt}), 32'd0);
  endtask

  initial begin
    logic [1:0]    op0, rop;
    logic [EW-1:0] pos0;
    logic [15:0]   exp_ok, exp_err;
    int            lvl;

    // Reset
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_pos_encode = '0;
    bus.csr_op_done = 2'd0; bus.rsp_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single add, engine answers 4 cycles after issue, rsp_ready held high
    push(2'd2, 18'h12345);
    tick();
    serve(4, 2'd2, 0);

    // Search answered with delete code, then an illegal op
    push(2'd1, 18'h00abc);
    tick();
    serve(3, 2'd3, 0);
    push(2'd0, 18'h3ffff);
    tick();
    serve(0, 2'd0, 0);

    // Engine silent: timeout, then the queued command issues
    push(2'd3, 18'h0f0f0);
    push(2'd2, 18'h10101);
    serve(100, 2'd0, 0);
    tick();
    serve(2, 2'd2, 0);

    // Match exactly at the timeout cycle wins
    push(2'd1, 18'h00001);
    tick();
    serve(TO, 2'd1, 0);

    // Response held off for 10 cycles with another command queued
    push(2'd2, 18'h22222);
    push(2'd3, 18'h33333);
    serve(3, 2'd2, 10);
    tick();
    serve(5, 2'd3, 0);

    // Done line stuck high after the response: drain times out
    push(2'd2, 18'h04444);
    tick();
    check("stuck_issue", 32'(bus.csr_ctrl), 32'd2);
    void'(exp_q.pop_front());
    bus.csr_op_done = 2'd2;
    tick();
    check("stuck_rsp", 32'({bus.rsp_valid, bus.rsp_status}), 32'({1'b1, 2'd0}));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    ok_n++;
    repeat (TO - 2) tick();
    check("stuck_busy", 32'(bus.busy), 32'd1);
    tick();
    check("stuck_idle", 32'(bus.busy), 32'd0);
    check("stuck_status_kept", 32'({bus.rsp_valid, bus.rsp_status}), 32'd0);
    bus.csr_op_done = 2'd0;
    tick();

    // Fill the FIFO with the engine stalled
    lvl = 0;
    for (int i = 0; i < 9; i++) begin
      push(2'($urandom_range(1, 3)), EW'($urandom));
      lvl++;
      if (i == 1) lvl--;  // first command is popped on the second push edge
    end
    check("full_level", 32'(bus.queue_level), 32'(lvl));
    check("full_ready", 32'(bus.cmd_ready), 32'd0);
    check("full_busy", 32'(bus.busy), 32'd1);
    {op0, pos0} = exp_q.pop_front();
    check("full_ctrl", 32'(bus.csr_ctrl), 32'(op0));
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_pos_encode = 18'h15555;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("full_blocked", 32'({bus.cmd_ready, 4'(bus.queue_level)}), 32'({1'b0, 4'(lvl)}));
    end
    bus.cmd_valid = 1'b0;
    bus.csr_op_done = op0;
    tick();
    check("full_first_rsp", 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_status}),
          32'({1'b1, op0, 2'd0}));
    check("full_first_pos", 32'(bus.csr_pos_encode), 32'(pos0));
    bus.csr_op_done = 2'd0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    ok_n++;
    tick();
    check("after_pop_level", 32'(bus.queue_level), 32'(lvl - 1));
    check("after_pop_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      serve($urandom_range(1, 6), exp_q[0][EW+1:EW], $urandom_range(0, 1));
    end
    tick();
    check("drained_busy", 32'(bus.busy), 32'd0);

    // Randomized single commands
    for (int i = 0; i < 12; i++) begin
      op0 = 2'($urandom_range(0, 3));
      rop = ($urandom_range(0, 1) == 1) ? op0 : 2'($urandom_range(0, 3));
      push(op0, EW'($urandom));
      tick();
      serve($urandom_range(1, TO + 4), rop, $urandom_range(0, 2));
    end

    // Statistics
`ifdef OCTREE_CMDQ_STATS_EN
    exp_ok = 16'(ok_n); exp_err = 16'(err_n);
`else
    exp_ok = 16'd0; exp_err = 16'd0;
`endif
    check("stat_ok", 32'(bus.stat_ok_cnt), 32'(exp_ok));
    check("stat_err", 32'(bus.stat_err_cnt), 32'(exp_err));

    // Reset pulse in WAIT drops everything
    push(2'd1, 18'h01234);
    push(2'd3, 18'h05678);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    ok_n = 0; err_n = 0;
    repeat (3) tick();
    check("post_reset_idle", 32'({bus.busy, bus.csr_ctrl, bus.rsp_valid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
